// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL lock / staged reset sequencer.
package pll_rst_pkg;

  localparam int unsigned LOCK_STABLE_CYCLES_DEF = 4096;
  localparam int unsigned STAGGER_CYCLES_DEF     = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    STAGGER   = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Generic N-stage single-bit synchroniser with synchronous active-high clear.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_seq.sv
// Qualifies the PLL lock and releases core then peripheral resets; re-asserts both on loss.
// Optional lock-loss counter enabled by defining PLL_LOCK_RST_SEQ_LOSS_CNT_EN.
module pll_lock_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned STAGGER_CYCLES     = STAGGER_CYCLES_DEF
`ifdef PLL_LOCK_RST_SEQ_LOSS_CNT_EN
  , parameter int unsigned LOSS_CNT_W       = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  lock_lost_clr,
  output logic                  rst_core,
  output logic                  rst_periph,
  output logic                  sys_ready,
  output logic                  lock_lost
`ifdef PLL_LOCK_RST_SEQ_LOSS_CNT_EN
  , output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(max_u(LOCK_STABLE_CYCLES, STAGGER_CYCLES));
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  seq_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             locked_s;
  logic             loss;
  logic             rst_core_d, rst_periph_d, sys_ready_d, lock_lost_d;
`ifdef PLL_LOCK_RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_d;
`endif

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_locked (
    .clk(clk),
    .rst(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );

  // Next state, counter and next registered output values.
  // Entering QUALIFY counts the t0 cycle as the first stable cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    loss    = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) begin
          state_d = QUALIFY;
          cnt_d   = CNT_W'(1);
        end
      end
      QUALIFY: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt == QUAL_LAST) begin
          state_d = STAGGER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STAGGER: begin
        if (!locked_s) begin
          loss    = 1'b1;
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt == STAG_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          loss    = 1'b1;
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    rst_core_d   = !((state_d == STAGGER) || (state_d == RUN));
    rst_periph_d = (state_d != RUN);
    sys_ready_d  = (state_d == RUN);

    // A loss coinciding with a clear wins.
    lock_lost_d = lock_lost;
    if (loss) begin
      lock_lost_d = 1'b1;
    end else if (lock_lost_clr) begin
      lock_lost_d = 1'b0;
    end

`ifdef PLL_LOCK_RST_SEQ_LOSS_CNT_EN
    loss_cnt_d = loss_cnt;
    if (loss) begin
      if (lock_lost_clr) begin
        loss_cnt_d = LOSS_CNT_W'(1);
      end else if (loss_cnt != '1) begin
        loss_cnt_d = loss_cnt + 1'b1;
      end
    end else if (lock_lost_clr) begin
      loss_cnt_d = '0;
    end
`endif
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      rst_core   <= 1'b1;
      rst_periph <= 1'b1;
      sys_ready  <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      rst_core   <= rst_core_d;
      rst_periph <= rst_periph_d;
      sys_ready  <= sys_ready_d;
      lock_lost  <= lock_lost_d;
    end
  end

`ifdef PLL_LOCK_RST_SEQ_LOSS_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt <= '0;
    end else begin
      loss_cnt <= loss_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed self-checking bench for pll_lock_rst_seq (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=4).
// loss_cnt checks are compiled in only when PLL_LOCK_RST_SEQ_LOSS_CNT_EN is defined.
module tb_pll_lock_rst_seq;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;
  logic lock_lost_clr;
  logic rst_core;
  logic rst_periph;
  logic sys_ready;
  logic lock_lost;
`ifdef PLL_LOCK_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  int exp_cnt    = 0;

  always #5 clk = ~clk;

  pll_lock_rst_seq #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .STAGGER_CYCLES    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .lock_lost_clr(lock_lost_clr),
    .rst_core     (rst_core),
    .rst_periph   (rst_periph),
    .sys_ready    (sys_ready),
    .lock_lost    (lock_lost)
`ifdef PLL_LOCK_RST_SEQ_LOSS_CNT_EN
    , .loss_cnt   (loss_cnt)
`endif
  );

  // Advance n clock edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic core, input logic periph,
                         input logic ready, input logic lost);
    chk({tag, ".rst_core"},   32'(rst_core),   32'(core));
    chk({tag, ".rst_periph"}, 32'(rst_periph), 32'(periph));
    chk({tag, ".sys_ready"},  32'(sys_ready),  32'(ready));
    chk({tag, ".lock_lost"},  32'(lock_lost),  32'(lost));
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef PLL_LOCK_RST_SEQ_LOSS_CNT_EN
    chk({tag, ".loss_cnt"}, 32'(loss_cnt), 32'(exp));
`endif
  endtask

  // Bounded wait for rst_core to reach v; timeout is a failed comparison.
  task automatic wait_core(input logic v, input string tag);
    int n;
    n = 0;
    while (rst_core !== v && n < 50) begin
      step(1);
      n++;
    end
    chk({tag, ".wait_core"}, 32'(rst_core), 32'(v));
  endtask

  initial begin
    rst           = 1'b1;
    pll_locked    = 1'b0;
    lock_lost_clr = 1'b0;

    // Reset state
    step(3);
    chk_out("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_cnt("reset", 0);

    // Clean lock: pll_locked rises at c, released at c+10, RUN at c+14
    rst = 1'b0;
    step(2);
    pll_locked = 1'b1;
    step(9);
    chk("s1.core_before", 32'(rst_core), 32'd1);
    step(1);
    chk_out("s1.core_rel", 1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
    chk_out("s1.stagger_end", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_out("s1.run", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_cnt("s1.run", 0);

    // Loss in RUN: locked_s falls at d+2, outputs react at d+3
    pll_locked = 1'b0;
    step(2);
    chk_out("s3.pre_loss", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_out("s3.loss", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_cnt("s3.loss", 1);
    pll_locked = 1'b1;
    step(9);
    chk("s3.relock_hold", 32'(rst_core), 32'd1);
    step(1);
    chk_out("s3.relock_rel", 1'b0, 1'b1, 1'b0, 1'b1);
    step(3);
    chk("s3.periph_hold", 32'(rst_periph), 32'd1);
    step(1);
    chk_out("s3.run", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_cnt("s3.run", 1);

    // Glitch in QUALIFY: high 5, low 1, high -> release 8 cycles after re-qualification
    rst        = 1'b1;
    pll_locked = 1'b0;
    step(2);
    chk_out("s2.reset", 1'b1, 1'b1, 1'b0, 1'b0);
    rst        = 1'b0;
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(4);
    chk("s2.no_early_rel", 32'(rst_core), 32'd1);
    step(5);
    chk("s2.hold", 32'(rst_core), 32'd1);
    step(1);
    chk_out("s2.rel", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt("s2.rel", 0);
    step(4);
    chk_out("s2.run", 1'b0, 1'b0, 1'b1, 1'b0);

    // Loss during STAGGER: first a RUN loss, relock, then drop 2 cycles after core release
    pll_locked = 1'b0;
    step(3);
    chk_out("s4.loss1", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_cnt("s4.loss1", 1);
    pll_locked = 1'b1;
    step(10);
    chk_out("s4.core_rel", 1'b0, 1'b1, 1'b0, 1'b1);
    pll_locked = 1'b0;
    step(1);
    chk("s4.periph_a", 32'(rst_periph), 32'd1);
    step(1);
    chk_out("s4.stagger", 1'b0, 1'b1, 1'b0, 1'b1);
    step(1);
    chk_out("s4.loss2", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_cnt("s4.loss2", 2);

    // Clear coinciding with a loss: loss wins
    pll_locked = 1'b1;
    step(14);
    chk_out("s4.run", 1'b0, 1'b0, 1'b1, 1'b1);
    pll_locked = 1'b0;
    step(2);
    chk("s4.pre_coll", 32'(sys_ready), 32'd1);
    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
    chk_out("s4.collision", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_cnt("s4.collision", 1);

    // Saturation: 260 further loss events
    exp_cnt = 1;
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b1;
      wait_core(1'b0, "s5.rel");
      pll_locked = 1'b0;
      wait_core(1'b1, "s5.loss");
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk_cnt("s5.count", exp_cnt);
    end
    chk("s5.lost", 32'(lock_lost), 32'd1);
    chk_cnt("s5.sat", 255);

    // rst asserted during STAGGER aborts to reset values
    pll_locked = 1'b1;
    step(10);
    chk_out("s6.stagger", 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step(1);
    chk_out("s6.rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_cnt("s6.rst", 0);
    rst = 1'b0;
    step(9);
    chk("s6.relock_hold", 32'(rst_core), 32'd1);
    step(1);
    chk_out("s6.relock_rel", 1'b0, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_out("s6.run", 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear with no concurrent loss
    pll_locked = 1'b0;
    step(3);
    chk_out("s5.pre_clr", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_cnt("s5.pre_clr", 1);
    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
    chk("s5.clr_lost", 32'(lock_lost), 32'd0);
    chk_cnt("s5.clr", 0);
    step(2);
    chk("s5.clr_stays", 32'(lock_lost), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
